// File: rtl/vga_pkg.sv
// Shared VGA timing constants and capture FSM encoding, common to the
// timing generator and the capture block.
package vga_pkg;

    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int CHAR_W   = 9;
    localparam int CHAR_H   = 16;
    localparam int H_SYNC   = 96;
    localparam int V_SYNC   = 2;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_ARMED = 1'b1;

endpackage

// File: rtl/vga_edge_det.sv
// Input register plus previous-value register for one sync/valid line,
// with rise/fall strobes taken between the two.
module vga_edge_det (
    input  logic pclk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic d_p1;
    logic d_p2;

    always_ff @(posedge pclk) begin
        if (!reset) begin
            d_p1 <= 1'b0;
            d_p2 <= 1'b0;
        end else begin
            d_p1 <= d;
            d_p2 <= d_p1;
        end
    end

    assign q    = d_p1;
    assign rise = d_p1 & ~d_p2;
    assign fall = ~d_p1 & d_p2;

endmodule

// File: rtl/vga_capture.sv
// VGA stream sink: recovers pixel/cell position, emits frame-buffer writes
// one cycle after the input register, and checks line/frame timing.
module vga_capture #(
    parameter int H_TOTAL  = vga_pkg::H_TOTAL,
    parameter int V_TOTAL  = vga_pkg::V_TOTAL,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        valid,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic        wr_en,
    output logic [9:0]  wr_h,
    output logic [9:0]  wr_v,
    output logic [23:0] wr_rgb,
    output logic [6:0]  char_x,
    output logic [4:0]  char_y,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        locked,
    output logic        err_hlen,
    output logic        err_vlen,
    output logic        err_active
);
    import vga_pkg::*;

    localparam logic [9:0] HT_C      = 10'(H_TOTAL);
    localparam logic [9:0] VT_LAST_C = 10'(V_TOTAL - 1);
    localparam logic [9:0] HA_C      = 10'(H_ACTIVE);
    localparam logic [9:0] VA_C      = 10'(V_ACTIVE);
    localparam logic [3:0] SX_LAST   = 4'(CHAR_W - 1);
    localparam logic [3:0] SY_LAST   = 4'(CHAR_H - 1);

    logic        hs_fall, vs_fall, va_fall, vld_p1;
    logic [4:0]  unused_edge;
    logic [23:0] rgb_p1;

    state_t      state;
    logic        hchk, frame_err;
    logic [9:0]  hcnt, vcnt, rows, pix_h;
    logic [3:0]  sx, sy;
    logic [6:0]  cx;
    logic [4:0]  cy;

    logic armed, hlen_bad, vlen_bad, rows_bad, pixh_bad, in_range;
    logic wr_ok, ovf_bad, act_bad, any_bad, close_frame;

    // Stage p1: input registers and edge strobes
    vga_edge_det u_hs (.pclk(pclk), .reset(reset), .d(hsync), .q(unused_edge[0]),
                       .rise(unused_edge[1]), .fall(hs_fall));
    vga_edge_det u_vs (.pclk(pclk), .reset(reset), .d(vsync), .q(unused_edge[2]),
                       .rise(unused_edge[3]), .fall(vs_fall));
    vga_edge_det u_va (.pclk(pclk), .reset(reset), .d(valid), .q(vld_p1),
                       .rise(unused_edge[4]), .fall(va_fall));

    always_ff @(posedge pclk) begin
        if (!reset) rgb_p1 <= '0;
        else        rgb_p1 <= {vga_r, vga_g, vga_b};
    end

    assign armed       = (state == ST_ARMED);
    assign close_frame = armed && vs_fall;
    // The first line after arming has an unknown start, so its length is not judged.
    assign hlen_bad    = armed && hs_fall && hchk && (hcnt != HT_C);
    assign vlen_bad    = close_frame && (vcnt != VT_LAST_C);
    assign rows_bad    = close_frame && (rows != VA_C);
    assign pixh_bad    = armed && va_fall && (pix_h != HA_C);
    assign in_range    = (pix_h < HA_C) && (rows < VA_C);
    assign wr_ok       = armed && vld_p1 && in_range;
    assign ovf_bad     = armed && vld_p1 && !in_range;
    assign act_bad     = rows_bad || pixh_bad || ovf_bad;
    assign any_bad     = hlen_bad || vlen_bad || act_bad;

    always_ff @(posedge pclk) begin
        if (!reset) begin
            state <= ST_IDLE;
            hchk  <= 1'b0;
            hcnt  <= '0;
            vcnt  <= '0;
            rows  <= '0;
            pix_h <= '0;
            sx    <= '0;
            cx    <= '0;
            sy    <= '0;
            cy    <= '0;
        end else begin
            if (vs_fall) state <= ST_ARMED;

            if (!armed)       hchk <= 1'b0;
            else if (hs_fall) hchk <= 1'b1;

            if (hs_fall)              hcnt <= 10'd1;
            else if (hcnt != 10'h3FF) hcnt <= hcnt + 10'd1;

            if (vs_fall)                         vcnt <= '0;
            else if (hs_fall && vcnt != 10'h3FF) vcnt <= vcnt + 10'd1;

            if (vs_fall)                         rows <= '0;
            else if (va_fall && rows != 10'h3FF) rows <= rows + 10'd1;

            if (va_fall) begin
                pix_h <= '0;
                sx    <= '0;
                cx    <= '0;
            end else if (vld_p1) begin
                if (pix_h != 10'h3FF) pix_h <= pix_h + 10'd1;
                if (sx == SX_LAST) begin
                    sx <= '0;
                    cx <= cx + 7'd1;
                end else begin
                    sx <= sx + 4'd1;
                end
            end

            if (vs_fall) begin
                sy <= '0;
                cy <= '0;
            end else if (va_fall) begin
                if (sy == SY_LAST) begin
                    sy <= '0;
                    cy <= cy + 5'd1;
                end else begin
                    sy <= sy + 4'd1;
                end
            end
        end
    end

    // Stage p2: write stream, frame status and sticky error flags
    always_ff @(posedge pclk) begin
        if (!reset) begin
            wr_en      <= 1'b0;
            wr_h       <= '0;
            wr_v       <= '0;
            wr_rgb     <= '0;
            char_x     <= '0;
            char_y     <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            locked     <= 1'b0;
            frame_err  <= 1'b0;
            err_hlen   <= 1'b0;
            err_vlen   <= 1'b0;
            err_active <= 1'b0;
        end else begin
            wr_en      <= wr_ok;
            wr_h       <= wr_ok ? pix_h  : '0;
            wr_v       <= wr_ok ? rows   : '0;
            wr_rgb     <= wr_ok ? rgb_p1 : '0;
            char_x     <= wr_ok ? cx     : '0;
            char_y     <= wr_ok ? cy     : '0;
            frame_done <= close_frame;

            // Errors seen on the closing edge belong to the frame being closed.
            if (close_frame) begin
                frame_cnt <= frame_cnt + 16'd1;
                locked    <= !(frame_err || any_bad);
                frame_err <= 1'b0;
            end else if (any_bad) begin
                frame_err <= 1'b1;
            end

            err_hlen   <= err_hlen   || hlen_bad;
            err_vlen   <= err_vlen   || vlen_bad;
            err_active <= err_active || act_bad;
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture: a reduced-geometry instance driven frame by frame
// from a table, plus a full-geometry instance for the far-corner pixel.
module tb_vga_capture;

    localparam int S_HT = 40;
    localparam int S_HS = 4;
    localparam int S_HB = 6;
    localparam int S_HA = 27;
    localparam int S_VT = 24;
    localparam int S_VS = 2;
    localparam int S_VB = 3;
    localparam int S_VA = 18;

    logic pclk = 1'b0;
    logic reset;
    always #20 pclk = ~pclk;

    logic        s_hs, s_vs, s_va;
    logic [23:0] s_rgb;
    logic        s_wr_en, s_fd, s_locked, s_eh, s_ev, s_ea;
    logic [9:0]  s_wr_h, s_wr_v;
    logic [23:0] s_wr_rgb;
    logic [6:0]  s_cx;
    logic [4:0]  s_cy;
    logic [15:0] s_fcnt;
    logic [77:0] s_all;

    logic        b_hs, b_vs, b_va;
    logic [23:0] b_rgb;
    logic        b_wr_en, b_fd, b_locked, b_eh, b_ev, b_ea;
    logic [9:0]  b_wr_h, b_wr_v;
    logic [23:0] b_wr_rgb;
    logic [6:0]  b_cx;
    logic [4:0]  b_cy;
    logic [15:0] b_fcnt;
    logic [77:0] b_all;

    vga_capture #(.H_TOTAL(S_HT), .V_TOTAL(S_VT), .H_ACTIVE(S_HA), .V_ACTIVE(S_VA)) u_small (
        .pclk(pclk), .reset(reset), .hsync(s_hs), .vsync(s_vs), .valid(s_va),
        .vga_r(s_rgb[23:16]), .vga_g(s_rgb[15:8]), .vga_b(s_rgb[7:0]),
        .wr_en(s_wr_en), .wr_h(s_wr_h), .wr_v(s_wr_v), .wr_rgb(s_wr_rgb),
        .char_x(s_cx), .char_y(s_cy), .frame_done(s_fd), .frame_cnt(s_fcnt),
        .locked(s_locked), .err_hlen(s_eh), .err_vlen(s_ev), .err_active(s_ea));

    vga_capture u_big (
        .pclk(pclk), .reset(reset), .hsync(b_hs), .vsync(b_vs), .valid(b_va),
        .vga_r(b_rgb[23:16]), .vga_g(b_rgb[15:8]), .vga_b(b_rgb[7:0]),
        .wr_en(b_wr_en), .wr_h(b_wr_h), .wr_v(b_wr_v), .wr_rgb(b_wr_rgb),
        .char_x(b_cx), .char_y(b_cy), .frame_done(b_fd), .frame_cnt(b_fcnt),
        .locked(b_locked), .err_hlen(b_eh), .err_vlen(b_ev), .err_active(b_ea));

    assign s_all = {s_wr_en, s_wr_h, s_wr_v, s_wr_rgb, s_cx, s_cy, s_fd, s_fcnt,
                    s_locked, s_eh, s_ev, s_ea};
    assign b_all = {b_wr_en, b_wr_h, b_wr_v, b_wr_rgb, b_cx, b_cy, b_fd, b_fcnt,
                    b_locked, b_eh, b_ev, b_ea};

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Write-stream monitor for the small instance
    int          wr_acc = 0, last_wr = 0, wr_total = 0, fd_total = 0, pix_bad = 0;
    logic [9:0]  ph = '0, pv = '0;

    function automatic bit pix_ok(input logic [9:0] h, input logic [9:0] v,
                                  input logic [6:0] cx, input logic [4:0] cy,
                                  input logic [23:0] rgb, input logic [9:0] h0,
                                  input logic [9:0] v0);
        bit seq;
        seq = (h == 10'd0 && v == 10'd0) || (h == h0 + 10'd1 && v == v0) ||
              (h == 10'd0 && v == v0 + 10'd1);
        return seq && int'(h) < S_HA && int'(v) < S_VA &&
               int'(cx) == int'(h) / 9 && int'(cy) == int'(v) / 16 &&
               rgb == {h[7:0], v[7:0], 8'hA5};
    endfunction

    always @(negedge pclk) begin
        if (!reset)                wr_acc <= 0;
        else if (s_fd) begin
            last_wr <= wr_acc;
            wr_acc  <= 0;
        end else if (s_wr_en)      wr_acc <= wr_acc + 1;
        if (s_wr_en) begin
            wr_total <= wr_total + 1;
            ph       <= s_wr_h;
            pv       <= s_wr_v;
            if (!pix_ok(s_wr_h, s_wr_v, s_cx, s_cy, s_wr_rgb, ph, pv)) pix_bad <= pix_bad + 1;
        end else if (s_cx != 7'd0 || s_cy != 5'd0) begin
            pix_bad <= pix_bad + 1;
        end
        if (s_fd) fd_total <= fd_total + 1;
    end

    logic [77:0] rst_snap = '1;
    int          rst_wr = -1;

    task automatic drive_frame(input int nlines, input int stretch_ln, input int short_ln,
                               input int rst_ln);
        int len, nact;
        bit act_row;
        for (int ln = 0; ln < nlines; ln++) begin
            len  = (ln == stretch_ln) ? S_HT + 1 : S_HT;
            nact = (ln == short_ln) ? S_HA - 1 : S_HA;
            act_row = (ln >= S_VB) && (ln < S_VB + S_VA);
            for (int c = 0; c < len; c++) begin
                s_hs  = (c >= S_HS);
                s_vs  = (ln >= S_VS);
                s_va  = act_row && (c >= S_HB) && (c < S_HB + nact);
                s_rgb = s_va ? {8'(c - S_HB), 8'(ln - S_VB), 8'hA5} : 24'h0;
                reset = !(ln == rst_ln && c == 10);
                @(posedge pclk); #1;
                if (!reset) begin
                    rst_snap = s_all;
                    rst_wr   = wr_total;
                end
            end
        end
        reset = 1'b1;
    endtask

    typedef struct {
        int nlines, stretch_ln, short_ln, rst_ln;
        int fd, cnt;
        bit locked, hlen, vlen, act;
        int wr;
    } vec_t;

    function automatic vec_t mk(input int nl, input int st, input int sh, input int rs,
                                input int fd, input int cnt, input bit lk, input bit eh,
                                input bit ev, input bit ea, input int wr);
        vec_t v;
        v.nlines = nl; v.stretch_ln = st; v.short_ln = sh; v.rst_ln = rs;
        v.fd = fd; v.cnt = cnt; v.locked = lk; v.hlen = eh; v.vlen = ev; v.act = ea;
        v.wr = wr;
        return v;
    endfunction

    vec_t vecs[13];

    initial begin
        int fd0;

        // Each row: frame shape, then status after the frame (locked/wr refer to the frame it closes).
        vecs[0]  = mk(24, -1, -1, -1, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(24, -1, -1, -1, 1, 1, 1, 0, 0, 0, 486);
        vecs[2]  = mk(24, -1, -1, -1, 1, 2, 1, 0, 0, 0, 486);
        vecs[3]  = mk(24,  5, -1, -1, 1, 3, 1, 1, 0, 0, 486);
        vecs[4]  = mk(24, -1, -1, -1, 1, 4, 0, 1, 0, 0, 486);
        vecs[5]  = mk(24, -1, -1, -1, 1, 5, 1, 1, 0, 0, 486);
        vecs[6]  = mk(23, -1, -1, -1, 1, 6, 1, 1, 0, 0, 486);
        vecs[7]  = mk(24, -1, -1, -1, 1, 7, 0, 1, 1, 0, 486);
        vecs[8]  = mk(24, -1, 10, -1, 1, 8, 1, 1, 1, 1, 486);
        vecs[9]  = mk(24, -1, -1, -1, 1, 9, 0, 1, 1, 1, 485);
        vecs[10] = mk(24, -1, -1,  8, 1, 0, 0, 0, 0, 0, 486);
        vecs[11] = mk(24, -1, -1, -1, 0, 0, 0, 0, 0, 0, 486);
        vecs[12] = mk(24, -1, -1, -1, 1, 1, 1, 0, 0, 0, 486);

        reset = 1'b0;
        s_hs = 1'b1; s_vs = 1'b1; s_va = 1'b0; s_rgb = '0;
        b_hs = 1'b1; b_vs = 1'b1; b_va = 1'b0; b_rgb = '0;
        repeat (3) @(posedge pclk);
        #1;
        check("reset outputs small", s_all, 0);
        check("reset outputs big", b_all, 0);
        reset = 1'b1;
        repeat (3) @(posedge pclk);
        #1;

        // Full-geometry corner pixels: arm, pixel (0,0), 478 one-pixel rows, then a 640-pixel row.
        b_vs = 1'b0; @(posedge pclk); #1;
        b_vs = 1'b1; repeat (2) @(posedge pclk); #1;
        b_va = 1'b1; b_rgb = 24'hFFFFFF; @(posedge pclk); #1;
        b_va = 1'b0; b_rgb = 24'h0;      @(posedge pclk); #1;
        check("first pixel wr_en", b_wr_en, 1);
        check("first pixel wr_h", b_wr_h, 0);
        check("first pixel wr_v", b_wr_v, 0);
        check("first pixel char_x/char_y", {b_cx, b_cy}, 0);
        check("first pixel wr_rgb", b_wr_rgb, 24'hFFFFFF);
        for (int r = 0; r < 478; r++) begin
            b_va = 1'b1; @(posedge pclk); #1;
            b_va = 1'b0; repeat (2) @(posedge pclk); #1;
        end
        for (int i = 0; i < 640; i++) begin
            b_va  = 1'b1;
            b_rgb = (i == 639) ? 24'hFFFFFF : 24'h102030;
            @(posedge pclk); #1;
        end
        b_va = 1'b0; b_rgb = 24'h0;
        @(posedge pclk); #1;
        check("last pixel wr_en", b_wr_en, 1);
        check("last pixel wr_h", b_wr_h, 639);
        check("last pixel wr_v", b_wr_v, 479);
        check("last pixel char_x", b_cx, 71);
        check("last pixel char_y", b_cy, 29);
        check("last pixel wr_rgb", b_wr_rgb, 24'hFFFFFF);
        @(posedge pclk); #1;
        check("after row wr_en", b_wr_en, 0);
        check("short rows err_active", b_ea, 1);

        repeat (5) @(posedge pclk);
        #1;

        for (int i = 0; i < 13; i++) begin
            fd0 = fd_total;
            drive_frame(vecs[i].nlines, vecs[i].stretch_ln, vecs[i].short_ln, vecs[i].rst_ln);
            check($sformatf("v%0d frame_done pulses", i), fd_total - fd0, vecs[i].fd);
            check($sformatf("v%0d frame_cnt", i), s_fcnt, vecs[i].cnt);
            check($sformatf("v%0d locked", i), s_locked, vecs[i].locked);
            check($sformatf("v%0d err_hlen", i), s_eh, vecs[i].hlen);
            check($sformatf("v%0d err_vlen", i), s_ev, vecs[i].vlen);
            check($sformatf("v%0d err_active", i), s_ea, vecs[i].act);
            check($sformatf("v%0d writes in closed frame", i), last_wr, vecs[i].wr);
            check($sformatf("v%0d bad pixel writes", i), pix_bad, 0);
            if (vecs[i].rst_ln >= 0) begin
                check($sformatf("v%0d outputs after mid-frame reset", i), rst_snap, 0);
                check($sformatf("v%0d writes while idle", i), wr_total, rst_wr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
